fft_peak_finder: RTL and testbench
==================================

# fft_peak_finder

- Downstream of the FFT state machine: after the FFT signals completion, this block scans the FFT's result memory through its `Inspect`/`Result` read port.
- It finds the bin with the largest unsigned magnitude and reports that bin index and magnitude to the tuner's note/display logic.
- It holds the result until acknowledged.

## Interface
Parameters:
- `ADDR_W`, 8, bin address width (matches the FFT `Inspect` width).
- `DATA_W`, 16, magnitude width (matches the FFT `Result` width).
- `FIRST_BIN`, 1, first bin scanned; skips DC.
- `LAST_BIN`, 127, last bin scanned. Must satisfy `FIRST_BIN <= LAST_BIN < 2**ADDR_W`.
- `NOISE_FLOOR`, 16'h0040, minimum peak magnitude for a valid pitch. Used only with `PEAK_GATE_EN`.

Ports:
- `Clk` in 1: the single clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `Start` in 1: one-cycle pulse, driven by the FFT `Done`.
- `Ack` in 1: consumer has taken the result.
- `Result` in `DATA_W`: FFT magnitude for the address on `Inspect` one cycle earlier.
- `Inspect` out `ADDR_W`: bin address to the FFT read port.
- `PeakBin` out `ADDR_W`: index of the maximum bin.
- `PeakMag` out `DATA_W`: magnitude of the maximum bin.
- `Ready` out 1: idle and accepting `Start`.
- `Done` out 1: result valid and held.
- `NoSignal` out 1: peak below the noise floor. Present only with `PEAK_GATE_EN`.

## Operation
States are INIT, SCAN, DRAIN and DONE. `Ready` is high only in INIT; `Done` is high only in DONE; both are decoded from the state register.

- **INIT**
  - `Inspect` = 0.
  - `Start`=1 → SCAN. At the same edge: `Inspect` ← `FIRST_BIN`, `PeakMag` ← 0, `PeakBin` ← `FIRST_BIN`.
  - `Ack` is ignored.
- **SCAN**
  - `Inspect` increments by 1 each cycle.
  - A delayed copy of `Inspect`, `rd_addr`, pairs with `Result`.
  - From the second SCAN cycle onward, each cycle: if `Result > PeakMag` (unsigned, strict), then `PeakMag` ← `Result` and `PeakBin` ← `rd_addr`.
  - When `Inspect == LAST_BIN` → DRAIN.
- **DRAIN**
  - Compares the final `Result` (for bin `LAST_BIN`).
  - `Inspect` ← 0.
  - → DONE.
- **DONE**
  - `PeakBin`, `PeakMag` and `NoSignal` are frozen.
  - `Ack`=1 → INIT.
- **Ties:** strict greater-than means the lowest bin index wins.
- **Zero input:** all-zero results give `PeakBin`=`FIRST_BIN` and `PeakMag`=0.
- **`Start` outside INIT:** ignored. It is not queued.
- **`Start` and `Ack` together in DONE:** `Ack` wins and the next state is INIT. A new `Start` pulse is required to scan again.
- **`Reset`:** has priority over everything, in any state.
  - Mid-scan reset abandons the scan.
  - Next edge values: INIT, `Inspect`=0, `PeakBin`=0, `PeakMag`=0, `NoSignal`=0, so `Ready`=1 and `Done`=0.

## Timing
- N = `LAST_BIN` − `FIRST_BIN` + 1.
- With `Start` sampled at edge E0:
  - `Inspect` = `FIRST_BIN`+k during cycle k, for k = 0..N−1.
  - DRAIN is the cycle after edge E_N.
  - `Done` rises at edge E_{N+1} and stays high until the edge that samples `Ack`.
  - Defaults give N = 127, so `Done` rises 128 cycles after `Start`.
- The FFT read port must have exactly 1 cycle of read latency, registered `Result`. No other latency is supported.
- `Ready` falls at E0. It rises the cycle after `Ack` is sampled.
- `Ack` held high across DONE→INIT has no further effect.

## Configuration
- **`PEAK_GATE_EN` defined:**
  - The `NoSignal` port exists.
  - At the DRAIN→DONE edge, `NoSignal` ← (`PeakMag` including the final compare) < `NOISE_FLOOR`.
  - `NoSignal` is cleared on `Start` and on `Reset`.
  - `PeakBin` and `PeakMag` are reported unchanged either way.
- **`PEAK_GATE_EN` undefined:** the `NoSignal` port and its logic are absent. All other behaviour is identical.

## Test plan
- **Reset:** hold `Reset` 5 cycles, then release → `Ready`=1, `Done`=0, `Inspect`=0, `PeakBin`=0, `PeakMag`=0.
- **Single peak:** bench model has 1-cycle latency, bin 37=16'h1234, others 16'h0010; `Start` pulse → `Inspect` sweeps 1..127, `Done` rises exactly 128 cycles after `Start`, `PeakBin`=37, `PeakMag`=16'h1234; `Ack` → `Ready`=1 the next cycle.
- **Tie and edges:**
  - bins 5 and 90 both 16'h0800 → `PeakBin`=5.
  - bin 0=16'hFFFF (excluded) and bin 127=16'h0900 → `PeakBin`=127, `PeakMag`=16'h0900.
- **Ignored controls:**
  - `Start` pulsed during SCAN and again in DONE → no restart, results unchanged.
  - `Start` and `Ack` together in DONE → INIT, no new scan.
- **Reset mid-scan:** `Reset` while `Inspect`=60 → next cycle INIT with all outputs at reset values; a following `Start` produces a correct full scan.
- **`PEAK_GATE_EN` build:**
  - max 16'h003F → `NoSignal`=1.
  - max 16'h0040 → `NoSignal`=0.
  - `NoSignal` clears on the next `Start`.

Source files
------------

// File: rtl/fft_peak_finder.sv
// fft_peak_finder: scans the FFT result memory for the largest-magnitude bin and holds it until Ack.
// Define PEAK_GATE_EN to add the NOISE_FLOOR parameter and the NoSignal output.
module fft_peak_finder #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int FIRST_BIN = 1,
    parameter int LAST_BIN  = 127
`ifdef PEAK_GATE_EN
    , parameter logic [DATA_W-1:0] NOISE_FLOOR = 16'h0040
`endif
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Ack,
    input  logic [DATA_W-1:0] Result,
    output logic [ADDR_W-1:0] Inspect,
    output logic [ADDR_W-1:0] PeakBin,
    output logic [DATA_W-1:0] PeakMag,
    output logic              Ready,
    output logic              Done
`ifdef PEAK_GATE_EN
    , output logic            NoSignal
`endif
);
    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_BIN);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_BIN);

    typedef enum logic [1:0] {INIT, SCAN, DRAIN, DONE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] rd_addr;
    logic              launch, cmp;
    logic [DATA_W-1:0] mag_next;

    always_ff @(posedge Clk) state <= Reset ? INIT : state_next;

    always_comb begin
        state_next = state;
        case (state)
            INIT:    state_next = Start ? SCAN : INIT;
            SCAN:    state_next = (Inspect == LAST_A) ? DRAIN : SCAN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = Ack ? INIT : DONE;
            default: state_next = INIT;
        endcase
    end

    // The first SCAN cycle's Result belongs to the INIT address, so it is skipped.
    assign launch   = state == INIT && Start;
    assign cmp      = (state == DRAIN || (state == SCAN && Inspect != FIRST_A)) && Result > PeakMag;
    assign mag_next = cmp ? Result : PeakMag;
    assign Ready    = state == INIT;
    assign Done     = state == DONE;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Inspect <= '0;
            rd_addr <= '0;
            PeakBin <= '0;
            PeakMag <= '0;
        end else begin
            rd_addr <= Inspect;
            if (launch) begin
                Inspect <= FIRST_A;
                PeakBin <= FIRST_A;
                PeakMag <= '0;
            end else begin
                Inspect <= (state == SCAN) ? Inspect + 1'b1 : '0;
                PeakMag <= mag_next;
                if (cmp) PeakBin <= rd_addr;
            end
        end
    end

`ifdef PEAK_GATE_EN
    always_ff @(posedge Clk) begin
        if (Reset || launch) NoSignal <= 1'b0;
        else if (state == DRAIN) NoSignal <= mag_next < NOISE_FLOOR;
    end
`else
    // Without the gate every peak is reported as-is.
`endif
endmodule

// File: tb/tb_fft_peak_finder.sv
// tb_fft_peak_finder: directed table-driven bench for fft_peak_finder with a 1-cycle-latency result memory.
module tb_fft_peak_finder;
    logic        clk = 0;
    logic        reset = 1, start = 0, ack = 0;
    logic [15:0] result;
    logic [7:0]  inspect, peak_bin;
    logic [15:0] peak_mag;
    logic        ready, done;
`ifdef PEAK_GATE_EN
    logic        no_signal;
`endif
    logic [15:0] mem [256];
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) result <= mem[inspect];

    fft_peak_finder dut (
        .Clk(clk), .Reset(reset), .Start(start), .Ack(ack), .Result(result),
        .Inspect(inspect), .PeakBin(peak_bin), .PeakMag(peak_mag),
        .Ready(ready), .Done(done)
`ifdef PEAK_GATE_EN
        , .NoSignal(no_signal)
`endif
    );

    typedef struct {
        string       name;
        logic [15:0] bg;
        int          a;
        logic [15:0] va;
        int          b;
        logic [15:0] vb;
        logic [7:0]  eb;
        logic [15:0] em;
        logic        ens;
        bit          ack_with_start;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 256; i++) mem[i] = v.bg;
        mem[v.a] = v.va;
        mem[v.b] = v.vb;
    endtask

    task automatic run_scan(input vec_t v, input int extra);
        int lat;
        bit sweep_ok;
        logic [7:0] held_bin;
        load(v);
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        check({v.name, "/ready_fall"}, ready, 0);
`ifdef PEAK_GATE_EN
        check({v.name, "/ns_clear"}, no_signal, 0);
`endif
        lat = -1;
        sweep_ok = 1;
        for (int k = 0; k < 300; k++) begin
            if (k < 127 && inspect != 8'(k + 1)) sweep_ok = 0;
            if (done) begin
                lat = k;
                break;
            end
            start = (k == extra);
            @(negedge clk);
        end
        start = 0;
        check({v.name, "/sweep"}, sweep_ok, 1);
        check({v.name, "/latency"}, lat, 128);
        check({v.name, "/bin"}, peak_bin, v.eb);
        check({v.name, "/mag"}, peak_mag, v.em);
`ifdef PEAK_GATE_EN
        check({v.name, "/nosig"}, no_signal, v.ens);
`endif
        // Start alone in DONE must be ignored
        held_bin = peak_bin;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        check({v.name, "/done_hold"}, done, 1);
        check({v.name, "/bin_hold"}, peak_bin, held_bin);
        ack = 1;
        start = v.ack_with_start;
        @(negedge clk) ack = 0;
        start = 0;
        check({v.name, "/ready_after_ack"}, {ready, done}, 2'b10);
        repeat (3) @(negedge clk);
        check({v.name, "/no_rescan"}, {ready, inspect}, {1'b1, 8'd0});
    endtask

    initial begin
        vecs[0] = '{"single", 16'h0010, 37, 16'h1234, 37, 16'h1234, 8'd37, 16'h1234, 1'b0, 1'b0};
        vecs[1] = '{"tie", 16'h0000, 5, 16'h0800, 90, 16'h0800, 8'd5, 16'h0800, 1'b0, 1'b1};
        vecs[2] = '{"edges", 16'h0000, 0, 16'hFFFF, 127, 16'h0900, 8'd127, 16'h0900, 1'b0, 1'b0};
        vecs[3] = '{"zero", 16'h0000, 0, 16'h0000, 0, 16'h0000, 8'd1, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{"below", 16'h0000, 64, 16'h003F, 64, 16'h003F, 8'd64, 16'h003F, 1'b1, 1'b0};
        vecs[5] = '{"at_floor", 16'h0000, 10, 16'h0040, 10, 16'h0040, 8'd10, 16'h0040, 1'b0, 1'b0};
        vecs[6] = '{"first_last", 16'h0030, 1, 16'h0031, 127, 16'h0031, 8'd1, 16'h0031, 1'b1, 1'b0};

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        repeat (5) @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("reset/ready", ready, 1);
        check("reset/done", done, 0);
        check("reset/inspect", inspect, 0);
        check("reset/bin", peak_bin, 0);
        check("reset/mag", peak_mag, 0);
`ifdef PEAK_GATE_EN
        check("reset/nosig", no_signal, 0);
`endif

        foreach (vecs[i]) run_scan(vecs[i], -1);

        // Start pulsed mid-SCAN must neither restart nor shift the timing
        run_scan(vecs[0], 20);

        // Reset while Inspect is 60 abandons the scan
        load(vecs[2]);
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        for (int k = 0; k < 200 && inspect != 8'd60; k++) @(negedge clk);
        check("midreset/reached60", inspect, 60);
        reset = 1;
        @(negedge clk) reset = 0;
        check("midreset/state", {ready, done}, 2'b10);
        check("midreset/inspect", inspect, 0);
        check("midreset/bin", peak_bin, 0);
        check("midreset/mag", peak_mag, 0);
        run_scan(vecs[0], -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
